// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with byte-lane writes, optional post-reset clear and error flag.
// Latency: read data and rd_valid appear 1 cycle after the accepted read; err pulses 1 cycle after an out-of-range access.
// Backpressure: busy=1 while the clear sequencer runs; requests presented then are dropped, not queued.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   en/we     access request / write select (qualified by en)
//   be        byte-lane write enables, bit i covers data_in[8i+7:8i]
//   addr      word address
//   data_in   write data
//   data_out  registered read data (zero for out-of-range reads)
//   rd_valid  1-cycle pulse: data_out holds the previous cycle's read result
//   err       1-cycle pulse: previous cycle's accepted access had addr >= DEPTH
//   busy      clear sequence in progress
module ram_sp_param #(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 8,
    parameter int                DEPTH   = 256,
    parameter int                RD_MODE = 0,
    parameter int                CLR_EN  = 1,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    output logic                  rd_valid,
    output logic                  err,
    output logic                  busy
);

    localparam int                NB        = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_ptr, clr_ptr_nxt;
    logic                clr_wr;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                in_range;
    logic                wr_en;
    logic                rd_en;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   merged;

    assign busy     = (state == CLEAR);
    assign accept   = en & ~busy;
    // Extra MSB keeps the compare correct when DEPTH == 2**ADDR_W.
    assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
    assign wr_en    = accept & we & in_range;
    assign rd_en    = accept & ~we;
    assign rd_word  = mem[addr];

    // Post-be word: untouched lanes keep the stored value.
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = data_in[8*i +: 8];
            end
        end
    end

    // Clear sequencer: one word per cycle, then RUN until the next reset.
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        clr_wr      = 1'b0;
        case (state)
            CLEAR: begin
                clr_wr      = 1'b1;
                clr_ptr_nxt = clr_ptr + 1'b1;
                if (clr_ptr == LAST_ADDR) begin
                    state_nxt = RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= (CLR_EN != 0) ? CLEAR : RUN;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    // Array carries no reset so contents survive a reset when CLR_EN=0.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[clr_ptr] <= CLR_VAL;
        end else if (wr_en) begin
            mem[addr] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            err      <= accept & ~in_range;
            if (rd_en) begin
                data_out <= in_range ? rd_word : '0;
            end else if (wr_en && (RD_MODE != 0)) begin
                // Write-first: expose the merged word without flagging a read.
                data_out <= merged;
            end
        end
    end

endmodule
